dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the internal data array (power of two, >=2).
REQ-002 Parameter LATENCY, default 2, cycles from request sample to response (legal range 1..15).
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 dmem_addr  in  32  byte address of request; bits [1:0] ignored, word index = dmem_addr[31:2].
REQ-006 dmem_rmask  in  4  byte read mask; nonzero = read request.
REQ-007 dmem_wmask  in  4  byte write mask; nonzero = write request.
REQ-008 dmem_wdata  in  32  write data, lane-aligned (byte i in bits 8i+7:8i).
REQ-009 dmem_rdata  out  32  read data word, valid when dmem_resp=1.
REQ-010 dmem_resp  out  1  one-cycle response strobe.
REQ-011 dmem_err  out  1  out-of-range flag, valid when dmem_resp=1.
REQ-012 mem_stall  out  1  pipeline stall to initiator; registered, no combinational path from any input.
REQ-013 bd_we  in  1  backdoor word write enable (test preload).
REQ-014 bd_addr  in  32  backdoor byte address, word index = bd_addr[31:2].
REQ-015 bd_wdata  in  32  backdoor full-word write data.

Function
REQ-016 Request accepted = (dmem_rmask|dmem_wmask) != 0 sampled on a rising edge while state is IDLE; inputs ignored in any other state.
REQ-017 States: IDLE (mem_stall=0), BUSY (mem_stall=1); no other states.
REQ-018 LATENCY=1: accepted request stays in IDLE; response in next cycle; mem_stall never asserted.
REQ-019 LATENCY>=2: IDLE->BUSY on accept, wait counter loaded with LATENCY-2; BUSY decrements each cycle; counter==0 in BUSY -> IDLE.
REQ-020 Request accepted at end of cycle T: mem_stall=1 in cycles T+1..T+LATENCY-1; dmem_resp=1 exactly in cycle T+LATENCY, mem_stall=0 that cycle.
REQ-021 Address, masks, wdata captured into internal request register at accept; later input changes have no effect on that request.
REQ-022 Array read and write for a request occur at the edge ending cycle T+LATENCY-1; dmem_rdata/dmem_err registered from that edge.
REQ-023 Write: for each i with wmask[i]=1, array byte i <= wdata[8i+7:8i]; other bytes unchanged.
REQ-024 Read: dmem_rdata = full stored word at index, all four bytes, irrespective of rmask.
REQ-025 rmask and wmask both nonzero: treated as write only; dmem_rdata=0.
REQ-026 Write-only response: dmem_rdata=0.
REQ-027 Out of range (word index >= DEPTH_WORDS): no array write, dmem_rdata=0, dmem_err=1.
REQ-028 New request may be accepted in the response cycle (back-to-back); one request per LATENCY cycles maximum throughput.
REQ-029 Read after write to same word, back-to-back, returns the written data.
REQ-030 dmem_rdata holds last value between responses; dmem_err and dmem_resp are 0 outside response cycle.
REQ-031 Backdoor write bd_we=1 writes full word each edge in any state; out-of-range index ignored; on same-edge collision with a request write to same index, backdoor wins.

Reset
REQ-032 rst=1: state IDLE, counter 0, request register cleared, mem_stall=0, dmem_resp=0, dmem_err=0, dmem_rdata=0 from next cycle.
REQ-033 rst during BUSY discards the outstanding request: no array write, no response.
REQ-034 Array contents are not reset; requests presented while rst=1 are not accepted.

Verification
REQ-035 LATENCY=2, backdoor word 4 = 0x11223344; lw addr 0x10 rmask 0xF -> stall 1 cycle, resp next cycle, rdata 0x11223344, err 0.
REQ-036 LATENCY=2, sb addr 0x13 wmask 0x8 wdata 0xAB000000, then lw 0x10 in resp cycle -> rdata 0xAB223344.
REQ-037 LATENCY=4, DEPTH_WORDS=1024, lw addr 0x1000 -> stall cycles T+1..T+3, resp at T+4, rdata 0, err 1.
REQ-038 LATENCY=3, sw addr 0x20 wdata 0xDEADBEEF, rst asserted at T+1 -> no resp, stall 0 after reset, later lw 0x20 returns prior contents.
REQ-039 LATENCY=1, three back-to-back lw to words 0,1,2 -> resp every cycle, mem_stall never 1, data in order.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
//   Fixed-latency data-memory responder with an internal word array and a
//   backdoor preload port. A request (any nonzero rmask/wmask) is accepted in
//   IDLE. The array is accessed LATENCY-1 cycles after the accept edge, and
//   the response strobe follows one cycle later.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   dmem_addr      request byte address (word index = addr[31:2])
//   dmem_rmask     byte read mask (nonzero = read)
//   dmem_wmask     byte write mask (nonzero = write, takes priority over read)
//   dmem_wdata     lane-aligned write data
//   dmem_rdata     read data, registered, holds between responses
//   dmem_resp      one-cycle response strobe
//   dmem_err       out-of-range flag, only high together with dmem_resp
//   mem_stall      registered stall, high while a request is outstanding
//   bd_we/bd_addr/bd_wdata  backdoor full-word write, wins over request writes

module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        dmem_err,
    output logic        mem_stall,
    input  logic        bd_we,
    input  logic [31:0] bd_addr,
    input  logic [31:0] bd_wdata
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t      state;
    logic [3:0]  cnt;

    logic [29:0] req_word;
    logic [3:0]  req_rmask;
    logic [3:0]  req_wmask;
    logic [31:0] req_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;

    // Access-edge view of the request: live inputs when LATENCY=1 (access on
    // the accept edge itself), otherwise the captured request register.
    logic        acc_fire;
    logic [29:0] acc_word;
    logic [3:0]  acc_rmask;
    logic [3:0]  acc_wmask;
    logic [31:0] acc_wdata;
    logic        acc_oor;
    logic        acc_write;
    logic        acc_read;
    logic [AW-1:0] acc_idx;

    logic [29:0]   bd_word;
    logic          bd_ok;
    logic [AW-1:0] bd_idx;

    logic unused_lsb;
    assign unused_lsb = &{1'b0, dmem_addr[1:0], bd_addr[1:0]};

    assign accept = !rst && (state == IDLE) && ((dmem_rmask | dmem_wmask) != '0);

    if (LATENCY == 1) begin : g_direct
        assign acc_fire  = accept;
        assign acc_word  = dmem_addr[31:2];
        assign acc_rmask = dmem_rmask;
        assign acc_wmask = dmem_wmask;
        assign acc_wdata = dmem_wdata;
        logic unused_req;
        assign unused_req = &{1'b0, req_word, req_rmask, req_wmask, req_wdata};
    end else begin : g_reg
        assign acc_fire  = !rst && (state == BUSY) && (cnt == '0);
        assign acc_word  = req_word;
        assign acc_rmask = req_rmask;
        assign acc_wmask = req_wmask;
        assign acc_wdata = req_wdata;
    end

    assign acc_oor   = {2'b00, acc_word} >= 32'(DEPTH_WORDS);
    assign acc_write = acc_wmask != '0;
    assign acc_read  = !acc_write && (acc_rmask != '0);
    assign acc_idx   = acc_word[AW-1:0];

    assign bd_word = bd_addr[31:2];
    assign bd_ok   = {2'b00, bd_word} < 32'(DEPTH_WORDS);
    assign bd_idx  = bd_word[AW-1:0];

    // Array: not reset. Backdoor write comes last so it wins on collision.
    always_ff @(posedge clk) begin
        if (acc_fire && !acc_oor && acc_write) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (acc_wmask[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
        if (bd_we && bd_ok) begin
            mem[bd_idx] <= bd_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_word   <= '0;
            req_rmask  <= '0;
            req_wmask  <= '0;
            req_wdata  <= '0;
            mem_stall  <= 1'b0;
            dmem_resp  <= 1'b0;
            dmem_err   <= 1'b0;
            dmem_rdata <= '0;
        end else begin
            dmem_resp <= acc_fire;
            dmem_err  <= acc_fire && acc_oor;
            if (acc_fire) begin
                dmem_rdata <= (acc_read && !acc_oor) ? mem[acc_idx] : '0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        req_word  <= dmem_addr[31:2];
                        req_rmask <= dmem_rmask;
                        req_wmask <= dmem_wmask;
                        req_wdata <= dmem_wdata;
                        if (LATENCY >= 2) begin
                            state     <= BUSY;
                            cnt       <= CNT_INIT;
                            mem_stall <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state     <= IDLE;
                        mem_stall <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_stall <= 1'b0;
                end
            endcase
        end
    end

endmodule
